// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper command path.
package stepper_pkg;

  localparam int unsigned DEF_SIZE  = 64;
  localparam int unsigned FRAC_BITS = DEF_SIZE >> 1;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_SETUP   = 3'd2,
    S_START   = 3'd3,
    S_ACK     = 3'd4,
    S_RUN     = 3'd5,
    S_RELEASE = 3'd6
  } seq_state_t;

endpackage

// File: rtl/move_delta.sv
// Relative move arithmetic: target - position as a signed word, split into
// direction and unsigned magnitude, with a flag when the move is unrepresentable.
module move_delta
  import stepper_pkg::*;
#(
  parameter int unsigned SIZE = DEF_SIZE
) (
  input  logic [SIZE-1:0] target_i,
  input  logic [SIZE-1:0] position_i,
  output logic [SIZE-1:0] magnitude_o,
  output logic            dir_o,
  output logic            overflow_o,
  output logic            zero_o
);

  localparam logic [SIZE-1:0] MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic [SIZE-1:0] ONE      = {{(SIZE-1){1'b0}}, 1'b1};

  logic [SIZE-1:0] delta_s;
  logic            sub_ovf_s;

  // Subtract and classify; the most-negative delta has no positive magnitude
  always_comb begin
    delta_s     = target_i - position_i;
    sub_ovf_s   = (target_i[SIZE-1] != position_i[SIZE-1]) &&
                  (delta_s[SIZE-1] != target_i[SIZE-1]);
    overflow_o  = sub_ovf_s || (delta_s == MOST_NEG);
    zero_o      = (delta_s == {SIZE{1'b0}});
    if (delta_s[SIZE-1]) begin
      magnitude_o = ~delta_s + ONE;
      dir_o       = DIR_NEG;
    end else begin
      magnitude_o = delta_s;
      dir_o       = DIR_POS;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Command sequencer in front of angle_to_step: turns absolute targets into
// direction + magnitude moves and runs the enable/done handshake for each move.
module move_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned SIZE        = DEF_SIZE,
  parameter int unsigned DIR_SETUP   = 25,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [SIZE-1:0] cmd_target_i,
  input  logic            cmd_home_i,
  input  logic            abort_i,
  output logic            step_enable_o,
  input  logic            step_done_i,
  output logic [SIZE-1:0] step_angle_o,
  output logic            dir_o,
  output logic            busy_o,
  output logic [SIZE-1:0] position_o,
  output logic            fault_o
);

  localparam int unsigned CNT_MAX = (DIR_SETUP > ACK_TIMEOUT) ? DIR_SETUP : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  // SETUP plus the single START cycle together give DIR_SETUP cycles of stable dir
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 2);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  seq_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] target_q, target_d;
  logic [SIZE-1:0] position_q, position_d;
  logic [SIZE-1:0] angle_q, angle_d;
  logic            dir_q, dir_d;
  logic            enable_q, enable_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;

  logic [SIZE-1:0] mag_s;
  logic            mdir_s, ovf_s, zero_s;
  logic            accept_s, abort_s;

  move_delta #(.SIZE(SIZE)) u_delta (
    .target_i    (target_q),
    .position_i  (position_q),
    .magnitude_o (mag_s),
    .dir_o       (mdir_s),
    .overflow_o  (ovf_s),
    .zero_o      (zero_s)
  );

  assign cmd_ready_o   = (state_q == S_IDLE) && !abort_i;
  assign accept_s      = cmd_valid_i && cmd_ready_o;
  assign abort_s       = abort_i && (state_q inside {S_SETUP, S_START, S_ACK, S_RUN});

  assign step_enable_o = enable_q;
  assign step_angle_o  = angle_q;
  assign dir_o         = dir_q;
  assign busy_o        = busy_q;
  assign position_o    = position_q;
  assign fault_o       = fault_q;

  // State register and all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      target_q   <= {SIZE{1'b0}};
      position_q <= {SIZE{1'b0}};
      angle_q    <= {SIZE{1'b0}};
      dir_q      <= 1'b0;
      enable_q   <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      position_q <= position_d;
      angle_q    <= angle_d;
      dir_q      <= dir_d;
      enable_q   <= enable_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and shared cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && !cmd_home_i && !fault_q) state_d = S_CALC;
        else                                     state_d = S_IDLE;
      end
      S_CALC: begin
        if (ovf_s || zero_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SETUP;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      S_SETUP: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = S_START;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_START: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      S_ACK: begin
        if (abort_s)                 state_d = S_IDLE;
        else if (!step_done_i)       state_d = S_RUN;
        else if (cnt_q == ACK_LAST)  state_d = S_IDLE;
        else                         cnt_d   = cnt_q + CNT_ONE;
      end
      S_RUN: begin
        if (abort_s)          state_d = S_IDLE;
        else if (step_done_i) state_d = S_RELEASE;
        else                  state_d = S_RUN;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and handshake outputs; abort in RUN outranks a coincident done
  always_comb begin
    target_d   = target_q;
    position_d = position_q;
    angle_d    = angle_q;
    dir_d      = dir_q;
    enable_d   = enable_q;
    fault_d    = fault_q;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept_s && cmd_home_i) begin
          position_d = cmd_target_i;
          fault_d    = 1'b0;
        end else if (accept_s && !fault_q) begin
          target_d   = cmd_target_i;
        end else begin
          target_d   = target_q;
        end
      end
      S_CALC: begin
        if (ovf_s) begin
          fault_d = 1'b1;
        end else if (!zero_s) begin
          dir_d   = mdir_s;
          angle_d = mag_s;
        end else begin
          fault_d = fault_q;
        end
      end
      S_SETUP, S_RUN: begin
        if (abort_s) begin
          fault_d  = 1'b1;
          enable_d = 1'b0;
        end else begin
          enable_d = enable_q;
        end
      end
      S_START: begin
        if (abort_s) begin
          fault_d  = 1'b1;
          enable_d = 1'b0;
        end else begin
          enable_d = 1'b1;
        end
      end
      S_ACK: begin
        if (abort_s || (step_done_i && (cnt_q == ACK_LAST))) begin
          fault_d  = 1'b1;
          enable_d = 1'b0;
        end else begin
          enable_d = enable_q;
        end
      end
      S_RELEASE: begin
        enable_d   = 1'b0;
        position_d = target_q;
      end
      default: enable_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer; models angle_to_step's done handshake inline.
module tb_move_sequencer;

  localparam int DIR_SETUP   = 25;
  localparam int ACK_TIMEOUT = 8;
  localparam int M_DONE = 0, M_TIMEOUT = 1, M_ABORT = 2, M_ABORT_DONE = 3, M_RESET = 4;

  typedef struct {
    logic        en;
    logic        dir;
    logic [63:0] ang;
    logic [63:0] pos;
    logic        flt;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_home_i, abort_i;
  logic [63:0] cmd_target_i;
  logic        step_enable_o, step_done_i, dir_o, busy_o, fault_o;
  logic [63:0] step_angle_o, position_o;

  exp_t        sb_q[$];
  logic [63:0] pos_m;
  logic        fault_m;
  int          errors = 0;
  int          checks = 0;

  move_sequencer #(.SIZE(64), .DIR_SETUP(DIR_SETUP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_target_i  (cmd_target_i),
    .cmd_home_i    (cmd_home_i),
    .abort_i       (abort_i),
    .step_enable_o (step_enable_o),
    .step_done_i   (step_done_i),
    .step_angle_o  (step_angle_o),
    .dir_o         (dir_o),
    .busy_o        (busy_o),
    .position_o    (position_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 65-bit difference so overflow is a plain range test
  task automatic predict(input logic [63:0] t, input logic home, input int mode, output exp_t e);
    logic [64:0] wide;
    logic [64:0] neg;
    e.en  = 1'b0;
    e.dir = 1'b0;
    e.ang = 64'h0;
    if (home) begin
      pos_m   = t;
      fault_m = 1'b0;
    end else if (!fault_m) begin
      wide = {t[63], t} - {pos_m[63], pos_m};
      neg  = 65'h0 - wide;
      if ((wide[64] != wide[63]) || (wide[63:0] == 64'h8000_0000_0000_0000)) begin
        fault_m = 1'b1;
      end else if (wide != 65'h0) begin
        e.en  = 1'b1;
        e.dir = ~wide[64];
        e.ang = wide[64] ? neg[63:0] : wide[63:0];
        case (mode)
          M_DONE:  pos_m = t;
          M_RESET: begin pos_m = 64'h0; fault_m = 1'b0; end
          default: fault_m = 1'b1;
        endcase
      end
    end
    e.pos = pos_m;
    e.flt = fault_m;
  endtask

  task automatic run_cmd(input string name, input logic [63:0] t, input logic home, input int mode);
    exp_t        e;
    exp_t        got_e;
    int          lat;
    logic        seen;
    logic        busy_first;
    logic [63:0] pos_before;
    busy_first = !home && !fault_m;
    pos_before = pos_m;
    predict(t, home, mode, e);
    sb_q.push_back(e);
    cmd_valid_i  = 1'b1;
    cmd_target_i = t;
    cmd_home_i   = home;
    lat = 0;
    while (!cmd_ready_o && lat < 10) begin @(negedge clk_i); lat++; end
    check({name, "_ready"}, 64'(cmd_ready_o), 64'h1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_home_i  = 1'b0;
    if (sb_q[0].en) begin
      lat = 0;
      while (!step_enable_o && lat < 60) begin @(negedge clk_i); lat++; end
      check({name, "_en_lat"}, 64'(lat), 64'(DIR_SETUP + 1));
      check({name, "_dir"}, 64'(dir_o), 64'(sb_q[0].dir));
      check({name, "_angle"}, step_angle_o, sb_q[0].ang);
      case (mode)
        M_DONE: begin
          @(negedge clk_i); step_done_i = 1'b0;
          repeat (4) @(negedge clk_i);
          step_done_i = 1'b1;
          @(negedge clk_i);
          check({name, "_pos_hold"}, position_o, pos_before);
          check({name, "_en_hold"}, 64'(step_enable_o), 64'h1);
          @(negedge clk_i);
          check({name, "_pos_upd"}, position_o, t);
          check({name, "_en_off"}, 64'(step_enable_o), 64'h0);
        end
        M_TIMEOUT: begin
          for (int k = 1; k <= ACK_TIMEOUT; k++) begin
            @(negedge clk_i);
            if (k == ACK_TIMEOUT - 1) check({name, "_flt_early"}, 64'(fault_o), 64'h0);
          end
          check({name, "_flt_tmo"}, 64'(fault_o), 64'h1);
          check({name, "_en_tmo"}, 64'(step_enable_o), 64'h0);
        end
        M_ABORT, M_ABORT_DONE: begin
          @(negedge clk_i); step_done_i = 1'b0;
          repeat (2) @(negedge clk_i);
          abort_i = 1'b1;
          if (mode == M_ABORT_DONE) step_done_i = 1'b1;
          @(negedge clk_i);
          check({name, "_en_abort"}, 64'(step_enable_o), 64'h0);
          check({name, "_flt_abort"}, 64'(fault_o), 64'h1);
          check({name, "_rdy_abort"}, 64'(cmd_ready_o), 64'h0);
          abort_i = 1'b0;
        end
        default: begin
          @(negedge clk_i); step_done_i = 1'b0;
          repeat (2) @(negedge clk_i);
          #2 rst_ni = 1'b0;
          #1;
          check({name, "_rst_out"},
                {step_enable_o, dir_o, busy_o, fault_o, (step_angle_o != 64'h0), (position_o != 64'h0)},
                64'h0);
          @(negedge clk_i);
          rst_ni = 1'b1;
        end
      endcase
      step_done_i = 1'b1;
    end else begin
      check({name, "_busy1"}, 64'(busy_o), 64'(busy_first));
      @(negedge clk_i);
      check({name, "_idle2"}, {62'h0, busy_o, cmd_ready_o}, 64'h1);
      seen = 1'b0;
      for (int i = 0; i < DIR_SETUP + 4; i++) begin
        @(negedge clk_i);
        if (step_enable_o) seen = 1'b1;
      end
      check({name, "_no_en"}, 64'(seen), 64'h0);
    end
    lat = 0;
    while (busy_o && lat < 40) begin @(negedge clk_i); lat++; end
    check({name, "_done_busy"}, 64'(busy_o), 64'h0);
    got_e = sb_q.pop_front();
    check({name, "_pos"}, position_o, got_e.pos);
    check({name, "_fault"}, 64'(fault_o), 64'(got_e.flt));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_ni       = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_home_i   = 1'b0;
    cmd_target_i = 64'h0;
    abort_i      = 1'b0;
    step_done_i  = 1'b1;
    pos_m        = 64'h0;
    fault_m      = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_outs", {step_enable_o, dir_o, busy_o, fault_o}, 64'h0);
    check("rst_angle", step_angle_o, 64'h0);
    check("rst_pos", position_o, 64'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_ready", 64'(cmd_ready_o), 64'h1);

    run_cmd("mv_p1_5",   64'h0000_0001_8000_0000, 1'b0, M_DONE);
    run_cmd("mv_m2",     64'hFFFF_FFFE_0000_0000, 1'b0, M_DONE);
    run_cmd("mv_same",   64'hFFFF_FFFE_0000_0000, 1'b0, M_DONE);
    run_cmd("mv_tmo",    64'h0000_0001_0000_0000, 1'b0, M_TIMEOUT);
    run_cmd("mv_disc",   64'h0000_0005_0000_0000, 1'b0, M_DONE);
    run_cmd("home0",     64'h0,                   1'b1, M_DONE);
    run_cmd("mv_abort",  64'h0000_0003_0000_0000, 1'b0, M_ABORT);
    run_cmd("home0b",    64'h0,                   1'b1, M_DONE);
    run_cmd("mv_abdone", 64'h0000_0001_0000_0000, 1'b0, M_ABORT_DONE);
    run_cmd("home_max",  64'h7FFF_FFFF_0000_0000, 1'b1, M_DONE);
    run_cmd("mv_ovf",    64'h8000_0000_0000_0000, 1'b0, M_DONE);
    run_cmd("home0c",    64'h0,                   1'b1, M_DONE);
    run_cmd("mv_rst",    64'h0000_0002_0000_0000, 1'b0, M_RESET);
    run_cmd("mv_neg",    64'hFFFF_FFFF_8000_0000, 1'b0, M_DONE);
    run_cmd("mv_back",   64'h0000_0000_4000_0000, 1'b0, M_DONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
